// File: rtl/instr_controller_if.sv
// Control bus between the instruction controller and the CPU datapath.
//   opcode/zero : instruction-register opcode and accumulator-zero flag (to controller)
//   sel..halt   : datapath enables decoded by the controller
//   phase       : current controller phase, for debug
// master = controller side, slave = datapath side.
interface instr_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       ld_ac;
  logic       inc_pc;
  logic       ld_pc;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
  );
endinterface

// File: rtl/instr_controller.sv
// Eight-phase instruction sequencer for a simple accumulator CPU.
// A free-running 3-bit phase counter walks fetch (PH0-PH3) and execute
// (PH4-PH7); all datapath enables are decoded combinationally from phase,
// opcode, zero and the halted flag. HLT seen in PH4 freezes the sequencer
// until reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : control bus (master side), see instr_controller_if
module instr_controller (
  input  logic                clk,
  input  logic                rst_n,
  instr_controller_if.master  bus
);

  typedef enum logic [2:0] {
    PH0_INST_ADDR  = 3'd0,
    PH1_INST_FETCH = 3'd1,
    PH2_INST_LOAD  = 3'd2,
    PH3_IDLE       = 3'd3,
    PH4_OP_ADDR    = 3'd4,
    PH5_OP_FETCH   = 3'd5,
    PH6_ALU_OP     = 3'd6,
    PH7_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   hlt_now;
  logic   alu_op;
  logic   sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;

  // HLT is only acted on at the end of PH4; that edge sets halted and
  // leaves the phase parked at 4.
  assign hlt_now = (phase_q == PH4_OP_ADDR) && (bus.opcode == OP_HLT);
  assign alu_op  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_comb begin
    halted_d = halted_q | hlt_now;
    phase_d  = phase_q;
    if (!halted_q && !hlt_now) phase_d = phase_e'(phase_q + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH0_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      // Everything quiet except halt; opcode and zero are ignored.
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH0_INST_ADDR:  sel = 1'b1;
        PH1_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PH2_INST_LOAD,
        PH3_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH4_OP_ADDR: begin
          inc_pc = (bus.opcode != OP_HLT);
          halt   = (bus.opcode == OP_HLT);
        end
        PH5_OP_FETCH:   rd = alu_op;
        PH6_ALU_OP: begin
          rd     = alu_op;
          inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          ld_pc  = (bus.opcode == OP_JMP);
          data_e = (bus.opcode == OP_STO);
        end
        PH7_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = (bus.opcode == OP_JMP);
          ld_pc  = (bus.opcode == OP_JMP);
          wr     = (bus.opcode == OP_STO);
          data_e = (bus.opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.wr     = wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.inc_pc = inc_pc;
  assign bus.ld_pc  = ld_pc;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;
  assign bus.phase  = phase_q;

endmodule
